// File: rtl/keypad_scan_debouncer.sv
// Keypad scanner for a 4x4 active-low matrix. It steps the column drive,
// synchronises the rows, debounces presses and releases on scan ticks, and
// emits one pulse per accepted key.
//
// state    | meaning
// ---------+----------------------------------------------------------
// SCAN     | rotate the column drive each tick until a row reads low
// DEBOUNCE | column frozen; count ticks that see the same key
// EMIT     | one clock: update num/opt and pulse the matching output
// HOLD     | column frozen; wait for DEBOUNCE_TICKS clean-release ticks
module keypad_scan_debouncer #(
   parameter int SCAN_DIV       = 2500,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] num,
   output logic       numPressed,
   output logic [2:0] opt,
   output logic       optPressed,
   output logic       submit
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_EMIT,
      ST_HOLD
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    rs1_q, rs_q;
   logic [DW-1:0] div_q;
   logic [3:0]    col_q, col_d;
   logic [3:0]    key_q, key_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] rel_q, rel_d;
   logic [3:0]    num_q, num_d;
   logic [2:0]    opt_q, opt_d;
   logic          np_q, np_d;
   logic          op_q, op_d;
   logic          sb_q, sb_d;

   logic          tick;
   logic          key_hit;
   logic [1:0]    row_idx;
   logic [1:0]    col_idx;
   logic [3:0]    key_now;
   logic [3:0]    col_rot;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] rel_inc;
   logic          go_emit;

   // Two-flop synchroniser for the asynchronous row pins; idle level is all-high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rs1_q <= 4'b1111;
         rs_q  <= 4'b1111;
      end else begin
         rs1_q <= row;
         rs_q  <= rs1_q;
      end
   end

   // Free-running scan divider; it never pauses, so dwell timing is state-independent.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q <= '0;
      end else if (div_q == DIV_LAST) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DW'(1);
      end
   end

   assign tick    = (div_q == DIV_LAST);
   assign key_hit = ~&rs_q;
   assign col_rot = {col_q[2:0], col_q[3]};
   assign cnt_inc = cnt_q + CW'(1);
   assign rel_inc = rel_q + CW'(1);
   assign key_now = {row_idx, col_idx};

   // Key index from the lowest low row and the column currently driven low.
   always_comb begin
      row_idx = 2'd3;
      if (!rs_q[0])      row_idx = 2'd0;
      else if (!rs_q[1]) row_idx = 2'd1;
      else if (!rs_q[2]) row_idx = 2'd2;
      col_idx = 2'd3;
      case (col_q)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         default: col_idx = 2'd3;
      endcase
   end

   // Next-state logic; pulses are registered so they line up with the num/opt update.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      rel_d   = rel_q;
      num_d   = num_q;
      opt_d   = opt_q;
      np_d    = 1'b0;
      op_d    = 1'b0;
      sb_d    = 1'b0;
      go_emit = 1'b0;
      case (state_q)
         ST_SCAN: begin
            if (tick) begin
               if (key_hit) begin
                  key_d = key_now;
                  cnt_d = CW'(1);
                  if (CNT_DONE == CW'(1)) go_emit = 1'b1;
                  else                    state_d = ST_DEBOUNCE;
               end else begin
                  col_d = col_rot;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (tick) begin
               if (key_hit && (key_now == key_q)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) go_emit = 1'b1;
               end else begin
                  state_d = ST_SCAN;
                  col_d   = col_rot;
               end
            end
         end
         ST_EMIT: begin
            state_d = ST_HOLD;
            rel_d   = '0;
         end
         ST_HOLD: begin
            if (tick) begin
               if (!key_hit) begin
                  if (rel_inc == CNT_DONE) begin
                     state_d = ST_SCAN;
                     col_d   = col_rot;
                     rel_d   = '0;
                  end else begin
                     rel_d = rel_inc;
                  end
               end else begin
                  rel_d = '0;
               end
            end
         end
         default: state_d = ST_SCAN;
      endcase
      // The key sampled on the accepting tick equals the latched key on every path here.
      if (go_emit) begin
         state_d = ST_EMIT;
         if (key_now <= 4'd9) begin
            num_d = key_now;
            np_d  = 1'b1;
         end else if (key_now <= 4'd14) begin
            opt_d = 3'(key_now - 4'd10);
            op_d  = 1'b1;
         end else begin
            sb_d  = 1'b1;
         end
      end
   end

   // Controller state, column drive, counters and outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_SCAN;
         col_q   <= 4'b1110;
         key_q   <= '0;
         cnt_q   <= '0;
         rel_q   <= '0;
         num_q   <= '0;
         opt_q   <= '0;
         np_q    <= 1'b0;
         op_q    <= 1'b0;
         sb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
         num_q   <= num_d;
         opt_q   <= opt_d;
         np_q    <= np_d;
         op_q    <= op_d;
         sb_q    <= sb_d;
      end
   end

   assign col        = col_q;
   assign num        = num_q;
   assign opt        = opt_q;
   assign numPressed = np_q;
   assign optPressed = op_q;
   assign submit     = sb_q;

endmodule

// File: tb/tb_keypad_scan_debouncer.sv
// Bench for keypad_scan_debouncer: a physical keypad model drives the rows
// from a pressed-key mask and the DUT column drive; a tick-level behavioural
// model predicts col/num/opt/pulses, compared every clock.
module tb_keypad_scan_debouncer;

   localparam int SD = 4;
   localparam int DT = 3;
   localparam int P_SCAN = 0, P_DEB = 1, P_EMIT = 2, P_HOLD = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row, col, num;
   logic [2:0] opt;
   logic       numPressed, optPressed, submit;
   logic [15:0] press;

   int checks = 0;
   int errors = 0;
   int n_np = 0, n_op = 0, n_sb = 0;
   int np_edge = 0;

   always #5 clk = ~clk;

   keypad_scan_debouncer #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
      .clk(clk), .reset(reset), .row(row), .col(col), .num(num),
      .numPressed(numPressed), .opt(opt), .optPressed(optPressed), .submit(submit)
   );

   // Physical keypad: a pressed key pulls its row low when its column is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press[4*r+c] && !col[c]) row[r] = 1'b0;
   end

   typedef struct {
      int phase, ci, div, cand, streak, rel, num, opt, edges, detect_edge;
      logic [3:0] s1, s2;
      bit np, op, sb;
   } mstate_t;

   mstate_t ms;

   function automatic int lowest_low(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (!v[i]) return i;
      return -1;
   endfunction

   function automatic mstate_t m_reset();
      mstate_t n;
      n.phase = P_SCAN; n.ci = 0; n.div = 0; n.cand = 0; n.streak = 0; n.rel = 0;
      n.num = 0; n.opt = 0; n.edges = 0; n.detect_edge = 0;
      n.s1 = 4'hF; n.s2 = 4'hF; n.np = 0; n.op = 0; n.sb = 0;
      return n;
   endfunction

   // One clock of the keypad protocol, decided from the tick-sampled rows.
   function automatic mstate_t m_step(input mstate_t m, input logic [3:0] pins);
      mstate_t n;
      int seen;
      bit tick, accept;
      n = m; n.np = 0; n.op = 0; n.sb = 0; accept = 0;
      tick = (m.div == SD - 1);
      seen = (m.s2 != 4'hF) ? 4 * lowest_low(m.s2) + m.ci : -1;
      if (m.phase == P_EMIT) begin
         n.phase = P_HOLD; n.rel = 0;
      end else if (tick) begin
         case (m.phase)
            P_SCAN: if (seen >= 0) begin
                  n.cand = seen; n.streak = 1; n.detect_edge = m.edges + 1;
                  if (DT == 1) accept = 1; else n.phase = P_DEB;
               end else n.ci = (m.ci + 1) % 4;
            P_DEB: if (seen == m.cand) begin
                  n.streak = m.streak + 1;
                  if (n.streak >= DT) accept = 1;
               end else begin
                  n.phase = P_SCAN; n.ci = (m.ci + 1) % 4;
               end
            P_HOLD: if (seen < 0) begin
                  n.rel = m.rel + 1;
                  if (n.rel >= DT) begin n.phase = P_SCAN; n.ci = (m.ci + 1) % 4; end
               end else n.rel = 0;
            default: ;
         endcase
      end
      if (accept) begin
         n.phase = P_EMIT;
         if (n.cand < 10) begin n.num = n.cand; n.np = 1; end
         else if (n.cand < 15) begin n.opt = n.cand - 10; n.op = 1; end
         else n.sb = 1;
      end
      n.div = (m.div + 1) % SD;
      n.s2 = m.s1; n.s1 = pins; n.edges = m.edges + 1;
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) ms <= m_reset();
      else        ms <= m_step(ms, row);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin : cmp
      logic [3:0] ecol;
      if (reset) begin
         ecol = ~(4'b0001 << ms.ci);
         chk("col", int'(col), int'(ecol));
         chk("num", int'(num), ms.num);
         chk("opt", int'(opt), ms.opt);
         chk("numPressed", int'(numPressed), int'(ms.np));
         chk("optPressed", int'(optPressed), int'(ms.op));
         chk("submit", int'(submit), int'(ms.sb));
         if (numPressed) begin n_np++; np_edge = ms.edges; end
         if (optPressed) n_op++;
         if (submit) n_sb++;
      end
   end

   task automatic wait_phase(input int ph, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (ms.phase == ph) return;
         @(negedge clk);
      end
      chk({name, "_timeout"}, ms.phase, ph);
   endtask

   initial begin
      reset = 1'b0;
      press = '0;
      repeat (3) @(negedge clk);
      chk("rst_col", int'(col), 4'b1110);
      chk("rst_num", int'(num), 0);
      chk("rst_opt", int'(opt), 0);
      chk("rst_pulses", int'({numPressed, optPressed, submit}), 0);
      reset = 1'b1;

      // 1: idle scan
      repeat (2) @(negedge clk); chk("t1_col_a", int'(col), 4'b1110);
      repeat (4) @(negedge clk); chk("t1_col_b", int'(col), 4'b1101);
      repeat (4) @(negedge clk); chk("t1_col_c", int'(col), 4'b1011);
      repeat (4) @(negedge clk); chk("t1_col_d", int'(col), 4'b0111);
      repeat (4) @(negedge clk); chk("t1_col_e", int'(col), 4'b1110);
      repeat (182) @(negedge clk);
      chk("t1_no_pulse", n_np + n_op + n_sb, 0);

      // 2: key 5, latency and no auto-repeat
      press = 16'h0020;
      wait_phase(P_HOLD, 200, "t2_hold");
      repeat (40) @(negedge clk);
      chk("t2_count", n_np, 1);
      chk("t2_num", int'(num), 5);
      chk("t2_latency", np_edge - ms.detect_edge, 2 * SD);
      press = '0;
      wait_phase(P_SCAN, 200, "t2_rel");

      // 3: key 12 then key 15
      press = 16'h1000;
      wait_phase(P_HOLD, 200, "t3_hold12");
      press = '0;
      wait_phase(P_SCAN, 200, "t3_rel12");
      press = 16'h8000;
      wait_phase(P_HOLD, 200, "t3_hold15");
      repeat (20) @(negedge clk);
      press = '0;
      wait_phase(P_SCAN, 200, "t3_rel15");
      chk("t3_opt_count", n_op, 1);
      chk("t3_opt", int'(opt), 2);
      chk("t3_submit_count", n_sb, 1);
      chk("t3_num_kept", int'(num), 5);
      chk("t3_np_count", n_np, 1);

      // 4: key 7 seen on a single tick only
      press = 16'h0080;
      wait_phase(P_DEB, 200, "t4_deb");
      press = '0;
      repeat (4) @(negedge clk);
      chk("t4_col_resume", int'(col), 4'b1110);
      repeat (8) @(negedge clk);
      chk("t4_no_event", n_np + n_op + n_sb, 3);

      // 5: key 3 with a bouncy release
      press = 16'h0008;
      wait_phase(P_HOLD, 200, "t5_hold");
      for (int i = 0; i < 20; i++) begin
         if (ms.div == 0) break;
         @(negedge clk);
      end
      press = '0;
      repeat (4) @(negedge clk);
      press = 16'h0008;
      repeat (4) @(negedge clk);
      press = '0;
      repeat (11) @(negedge clk);
      chk("t5_col_frozen", int'(col), 4'b0111);
      @(negedge clk);
      chk("t5_col_released", int'(col), 4'b1110);
      chk("t5_count", n_np, 2);
      chk("t5_num", int'(num), 3);

      // lowest row wins: keys 2 and 10 share column 2
      press = 16'h0404;
      wait_phase(P_HOLD, 200, "t7_hold");
      @(negedge clk);
      chk("t7_num", int'(num), 2);
      chk("t7_op_count", n_op, 1);
      press = '0;
      wait_phase(P_SCAN, 200, "t7_rel");

      // 6: reset during debounce of key 9
      press = 16'h0200;
      wait_phase(P_DEB, 200, "t6_deb");
      #2 reset = 1'b0;
      #1;
      chk("t6_col", int'(col), 4'b1110);
      chk("t6_num", int'(num), 0);
      chk("t6_opt", int'(opt), 0);
      chk("t6_pulses", int'({numPressed, optPressed, submit}), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_no_pulse_after_release", n_np, 3);
      wait_phase(P_HOLD, 200, "t6_rehold");
      @(negedge clk);
      chk("t6_redebounced", n_np, 4);
      chk("t6_num", int'(num), 9);
      press = '0;
      wait_phase(P_SCAN, 200, "t6_rel");
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
